// File: rtl/udp_cfg_axi_slave_if.sv
// AXI4-Lite channel bundle between the system interconnect and the UDP engine register block.
// The master modport drives requests and the slave modport drives responses.
interface udp_cfg_axi_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/udp_cfg_axi_slave.sv
// AXI4-Lite register block for the UDP engine: MAC/IP/port configuration, a TX frame
// counter and synchronised link status. One outstanding read and one outstanding write.
module udp_cfg_axi_slave #(
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter logic [47:0] C_RESET_MAC        = 48'h0,
  parameter logic [31:0] C_RESET_IP         = 32'h0
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  udp_cfg_axi_slave_if.slave  s_axi,
  input  logic                link_ok,
  input  logic                tx_done,
  output logic                cfg_enable,
  output logic [47:0]         cfg_mac,
  output logic [31:0]         cfg_ip,
  output logic [15:0]         cfg_src_port,
  output logic [15:0]         cfg_dst_port
);

  localparam int DW = C_S_AXI_DATA_WIDTH;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_MAC_LO  = 3'd1;
  localparam logic [2:0] A_MAC_HI  = 3'd2;
  localparam logic [2:0] A_IP      = 3'd3;
  localparam logic [2:0] A_PORTS   = 3'd4;
  localparam logic [2:0] A_STATUS  = 3'd5;
  localparam logic [2:0] A_TXCNT   = 3'd6;
  localparam logic [2:0] A_SCRATCH = 3'd7;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_val,
                                               input logic [DW-1:0] new_val,
                                               input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    for (int i = 0; i < DW/8; i++)
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

  logic [0:0]    r_wstate;
  logic [0:0]    r_rstate;
  logic          r_awready;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_arready;
  logic          r_rvalid;
  logic [1:0]    r_rresp;
  logic [DW-1:0] r_rdata;

  logic          r_ctrl_en;
  logic [31:0]   r_mac_lo;
  logic [15:0]   r_mac_hi;
  logic [31:0]   r_ip;
  logic [31:0]   r_ports;
  logic [31:0]   r_scratch;
  logic [31:0]   r_tx_count;
  logic          r_link_s1;
  logic          r_link_s2;

  logic          w_wr_commit;
  logic          w_rd_accept;
  logic          w_clear;
  logic [2:0]    w_waddr;
  logic [2:0]    w_raddr;
  logic [DW-1:0] w_wr_old;
  logic [DW-1:0] w_wr_new;
  logic [DW-1:0] w_rd_mux;
  logic          w_unused;

  assign w_waddr     = s_axi.awaddr[4:2];
  assign w_raddr     = s_axi.araddr[4:2];
  assign w_wr_commit = (r_wstate == W_IDLE) && r_awready && s_axi.awvalid && s_axi.wvalid;
  assign w_rd_accept = (r_rstate == R_IDLE) && r_arready && s_axi.arvalid;
  assign w_clear     = w_wr_commit && (w_waddr == A_CTRL) && s_axi.wstrb[0] && s_axi.wdata[1];

  // Stored view of the addressed register, so partial strobes merge with what is held.
  always_comb begin
    w_wr_old = '0;
    case (w_waddr)
      A_CTRL:    w_wr_old = {31'b0, r_ctrl_en};
      A_MAC_LO:  w_wr_old = r_mac_lo;
      A_MAC_HI:  w_wr_old = {16'b0, r_mac_hi};
      A_IP:      w_wr_old = r_ip;
      A_PORTS:   w_wr_old = r_ports;
      A_SCRATCH: w_wr_old = r_scratch;
      default:   w_wr_old = '0;
    endcase
  end

  assign w_wr_new = apply_strb(w_wr_old, s_axi.wdata, s_axi.wstrb);

  always_comb begin
    w_rd_mux = '0;
    case (w_raddr)
      A_CTRL:    w_rd_mux = {31'b0, r_ctrl_en};
      A_MAC_LO:  w_rd_mux = r_mac_lo;
      A_MAC_HI:  w_rd_mux = {16'b0, r_mac_hi};
      A_IP:      w_rd_mux = r_ip;
      A_PORTS:   w_rd_mux = r_ports;
      A_STATUS:  w_rd_mux = {31'b0, r_link_s2};
      A_TXCNT:   w_rd_mux = r_tx_count;
      A_SCRATCH: w_rd_mux = r_scratch;
      default:   w_rd_mux = '0;
    endcase
  end

  // Write channel: AW and W are only taken together, ready pulses one cycle.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (r_awready) begin
            r_awready <= 1'b0;
            if (w_wr_commit) begin
              r_bvalid <= 1'b1;
              r_bresp  <= 2'b00;
              r_wstate <= W_RESP;
            end
          end else if (s_axi.awvalid && s_axi.wvalid) begin
            r_awready <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel: data is captured on the AR handshake edge, before any coincident write lands.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (r_arready) begin
            r_arready <= 1'b0;
            if (w_rd_accept) begin
              r_rdata  <= w_rd_mux;
              r_rresp  <= 2'b00;
              r_rvalid <= 1'b1;
              r_rstate <= R_DATA;
            end
          end else if (s_axi.arvalid && !r_rvalid) begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            r_rvalid <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_ctrl_en <= 1'b0;
      r_mac_lo  <= C_RESET_MAC[31:0];
      r_mac_hi  <= C_RESET_MAC[47:32];
      r_ip      <= C_RESET_IP;
      r_ports   <= '0;
      r_scratch <= '0;
    end else if (w_wr_commit) begin
      case (w_waddr)
        A_CTRL:    r_ctrl_en <= w_wr_new[0];
        A_MAC_LO:  r_mac_lo  <= w_wr_new;
        A_MAC_HI:  r_mac_hi  <= w_wr_new[15:0];
        A_IP:      r_ip      <= w_wr_new;
        A_PORTS:   r_ports   <= w_wr_new;
        A_SCRATCH: r_scratch <= w_wr_new;
        default:   ;
      endcase
    end
  end

  // A clear on the same edge as a tx_done pulse drops that pulse.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_tx_count <= '0;
    end else if (w_clear) begin
      r_tx_count <= '0;
    end else if (tx_done) begin
      r_tx_count <= r_tx_count + 32'd1;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_link_s1 <= 1'b0;
      r_link_s2 <= 1'b0;
    end else begin
      r_link_s1 <= link_ok;
      r_link_s2 <= r_link_s1;
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_awready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = r_rdata;

  assign cfg_enable   = r_ctrl_en;
  assign cfg_mac      = {r_mac_hi, r_mac_lo};
  assign cfg_ip       = r_ip;
  assign cfg_src_port = r_ports[15:0];
  assign cfg_dst_port = r_ports[31:16];

  assign w_unused = ^{s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:5], s_axi.awaddr[1:0],
                      s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:5], s_axi.araddr[1:0],
                      s_axi.awprot, s_axi.arprot};

endmodule
